pipelined_addsub: RTL
=====================

Name: pipelined_addsub

Overview:
Parametrised, pipelined add/subtract unit; successor to the single-cycle combinational adder. The carry chain is split into STAGES equal chunks, one chunk per register stage, so wide adds close timing at high clock rates. Valid/ready handshake on both sides gives full backpressure. Outputs carry, signed overflow and zero flags. Sits in the datapath between operand fetch and writeback.

Parameters:
DATA_WIDTH, 32, operand/result width in bits
STAGES, 2, pipeline depth = carry-chain chunks; DATA_WIDTH % STAGES must be 0; legal range 1..DATA_WIDTH

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand set present
in_ready  output  1  unit accepts operand set this cycle
in0  input  DATA_WIDTH  operand A
in1  input  DATA_WIDTH  operand B
sub  input  1  0: A+B, 1: A-B
out_valid  output  1  result present
out_ready  input  1  consumer accepts result this cycle
out  output  DATA_WIDTH  result
carry  output  1  carry out of MSB (sub: 1 = no borrow)
overflow  output  1  two's-complement signed overflow
zero  output  1  out == 0

Behaviour:
- Chunk width CW = DATA_WIDTH/STAGES. Stage i (0..STAGES-1) adds bits [i*CW +: CW] using the stored carry from stage i-1; stage 0 carry-in = sub.
- Subtract: B operand replaced by ~in1 at capture; carry-in 1. No other mode logic.
- Upper chunks not yet summed travel as skewed operand registers; lower chunks already summed travel as partial-result registers.
- Stage STAGES-1 is the output register; out/carry/overflow/zero/out_valid driven directly from registers, no combinational path from inputs.
- overflow = carry into MSB XOR carry out of MSB, computed in final stage. zero from the full assembled result, registered with it.
- Per-stage valid bit v[i]. Advance rule: rdy[STAGES-1] = !v[STAGES-1] | out_ready; rdy[i] = !v[i] | rdy[i+1]. in_ready = rdy[0] (combinational from out_ready, allowed).
- Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready. Stage i loads from stage i-1 when rdy[i]; v[i] <= v[i-1] (v[-1] = in_valid). Bubbles collapse.
- Latency: result out_valid exactly STAGES cycles after the accept edge when unstalled. Throughput 1 op/cycle when out_ready held high.
- Stall: out_valid & !out_ready -> out and flags hold stable, no value changes until accepted. Capacity = STAGES operations; in_ready low only when all stages valid and out_ready low.
- Ordering strictly FIFO; no drop or duplication.
- Simultaneous accept-in and accept-out on a full pipe: legal, pipe shifts, stays full.
- Wrap-around: result modulo 2^DATA_WIDTH; carry reports the lost bit.
- Reset (rst_n low at clock edge): all v[i] = 0, out_valid = 0, out = 0, carry = 0, overflow = 0, zero = 0; in_ready = 1 in the cycle after reset. In-flight operations discarded, including mid-stall. Data registers other than outputs need not reset.
- in0/in1/sub sampled only on accept; ignored otherwise.

Test Plan:
- W=32,S=2: 0xFFFFFFFF+0x00000001, out_ready=1 -> out_valid 2 cycles after accept, out=0, carry=1, zero=1, overflow=0.
- 0x7FFFFFFF+0x00000001 -> 0x80000000, overflow=1, carry=0, zero=0; then sub 0x80000000-1 -> 0x7FFFFFFF, overflow=1, carry=1.
- sub 5-7 -> 0xFFFFFFFE, carry=0; sub 7-5 -> 0x00000002, carry=1; sub 9-9 -> 0, zero=1, carry=1.
- Stream 4 ops (1+1, 2+2, 3+3, 4+4) back to back, out_ready low from first out_valid: out=2 holds; in_ready drops after ops 1-2 captured; raise out_ready -> 2,4,6,8 in order, one per cycle, in_ready high.
- Two ops in flight plus stalled output; assert rst_n=0 one cycle -> out_valid=0, out=0, all flags 0 next cycle; in_ready=1; subsequent 3+4 -> 7 with normal 2-cycle latency.
- W=8,S=1: sub 0x80-0x01 -> 0x7F, overflow=1, carry=1, latency 1; W=8,S=4: 0xFF+0xFF -> 0xFE, carry=1, latency 4.

Source files
------------

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit. The carry chain is cut into STAGES equal
// chunks, one chunk summed per register stage, with valid/ready handshake
// and full backpressure on both sides. DATA_WIDTH must be a multiple of
// STAGES, with 1 <= STAGES <= DATA_WIDTH.
module pipelined_addsub #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in0,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  carry,
  output logic                  overflow,
  output logic                  zero
);

  localparam int unsigned CW  = DATA_WIDTH / STAGES;
  localparam int unsigned TOP = (STAGES - 1) * CW;

  logic [STAGES-1:0]     v;
  logic [STAGES-1:0]     rdy;
  logic [DATA_WIDTH-1:0] fin_res;
  logic                  fin_cout;
  logic                  fin_cmsb;
  logic                  fin_v;

  function automatic logic [CW:0] add_chunk(input logic [CW-1:0] a,
                                            input logic [CW-1:0] b,
                                            input logic          c);
    return {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, c};
  endfunction

  // Ready chain from the output back to the input: a stage may load when it
  // is empty or when the stage after it is moving.
  always_comb begin
    rdy = '0;
    rdy[STAGES-1] = ~v[STAGES-1] | out_ready;
    for (int unsigned i = STAGES - 1; i > 0; i--) begin
      rdy[i-1] = ~v[i-1] | rdy[i];
    end
  end

  assign in_ready       = rdy[0];
  assign v[STAGES-1]    = out_valid;

  if (STAGES > 1) begin : g_pipe
    localparam int unsigned NP = STAGES - 1;

    // Stage i holds: skewed operands (upper chunks still to be summed),
    // the partial result (chunks 0..i summed) and the carry out of chunk i.
    logic [DATA_WIDTH-1:0] a_p [NP];
    logic [DATA_WIDTH-1:0] b_p [NP];
    logic [DATA_WIDTH-1:0] s_p [NP];
    logic [NP-1:0]         c_p;
    logic [NP-1:0]         v_p;

    logic [DATA_WIDTH-1:0] na [NP];
    logic [DATA_WIDTH-1:0] nb [NP];
    logic [DATA_WIDTH-1:0] ns [NP];
    logic [NP-1:0]         nc;
    logic [NP-1:0]         nv;
    logic [CW:0]           t;
    logic [CW:0]           tf;

    assign v[NP-1:0] = v_p;

    // Next-state of each intermediate stage: sum its own chunk with the
    // carry stored by the previous stage; subtract inverts B at capture.
    always_comb begin
      t      = add_chunk(in0[CW-1:0], in1[CW-1:0] ^ {CW{sub}}, sub);
      na[0]  = in0;
      nb[0]  = in1 ^ {DATA_WIDTH{sub}};
      ns[0]  = '0;
      ns[0][CW-1:0] = t[CW-1:0];
      nc     = '0;
      nc[0]  = t[CW];
      nv     = '0;
      nv[0]  = in_valid;
      for (int unsigned i = 1; i < NP; i++) begin
        t     = add_chunk(a_p[i-1][i*CW +: CW], b_p[i-1][i*CW +: CW], c_p[i-1]);
        na[i] = a_p[i-1];
        nb[i] = b_p[i-1];
        ns[i] = s_p[i-1];
        ns[i][i*CW +: CW] = t[CW-1:0];
        nc[i] = t[CW];
        nv[i] = v_p[i-1];
      end
    end

    // Intermediate stage registers; only the valid bits are reset.
    always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NP; i++) begin
        if (!rst_n) begin
          v_p[i] <= 1'b0;
        end else if (rdy[i]) begin
          v_p[i] <= nv[i];
          a_p[i] <= na[i];
          b_p[i] <= nb[i];
          s_p[i] <= ns[i];
          c_p[i] <= nc[i];
        end
      end
    end

    // Final chunk sum feeding the output register.
    always_comb begin
      tf       = add_chunk(a_p[NP-1][TOP +: CW], b_p[NP-1][TOP +: CW], c_p[NP-1]);
      fin_res  = s_p[NP-1];
      fin_res[TOP +: CW] = tf[CW-1:0];
      fin_cout = tf[CW];
      fin_cmsb = a_p[NP-1][DATA_WIDTH-1] ^ b_p[NP-1][DATA_WIDTH-1] ^ fin_res[DATA_WIDTH-1];
      fin_v    = v_p[NP-1];
    end
  end else begin : g_single
    logic [DATA_WIDTH-1:0] bx;
    logic [CW:0]           tf;

    // Single stage: the whole word is one chunk summed straight from inputs.
    always_comb begin
      bx       = in1 ^ {DATA_WIDTH{sub}};
      tf       = add_chunk(in0, bx, sub);
      fin_res  = '0;
      fin_res[TOP +: CW] = tf[CW-1:0];
      fin_cout = tf[CW];
      fin_cmsb = in0[DATA_WIDTH-1] ^ bx[DATA_WIDTH-1] ^ fin_res[DATA_WIDTH-1];
      fin_v    = in_valid;
    end
  end

  // Output register: result and flags held stable while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (rdy[STAGES-1]) begin
      out_valid <= fin_v;
      if (fin_v) begin
        out      <= fin_res;
        carry    <= fin_cout;
        overflow <= fin_cmsb ^ fin_cout;
        zero     <= (fin_res == '0);
      end
    end
  end

endmodule
